// File: rtl/two_to_four_decoder_seq_pkg.sv
// Shared types and constants for the sequenced 2-to-4 decoder.
// The optional accepted-code counter is enabled by defining TWO_TO_FOUR_CNT_EN.
package two_to_four_decoder_seq_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [1:0] CODE_A = 2'b11;
    localparam logic [1:0] CODE_B = 2'b10;
    localparam logic [1:0] CODE_C = 2'b01;
    localparam logic [1:0] CODE_D = 2'b00;

    // Output vector ordering is {a, b, c, d}.
    typedef logic [3:0] onehot_t;

endpackage

// File: rtl/two_to_four_decoder_seq_decode_2to4.sv
// Pure combinational map from a 2-bit code to the one-hot {a, b, c, d} vector.
module decode_2to4
    import two_to_four_decoder_seq_pkg::*;
(
    input  logic [1:0] code,
    output onehot_t    onehot
);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        onehot = '0;
        unique case (code)
            CODE_A: onehot = 4'b1000;
            CODE_B: onehot = 4'b0100;
            CODE_C: onehot = 4'b0010;
            CODE_D: onehot = 4'b0001;
            default: onehot = '0;
        endcase
    end

endmodule

// File: rtl/two_to_four_decoder_seq.sv
// Sequenced 2-to-4 decoder: holds a one-hot output for HOLD_CYCLES, then idles for GAP_CYCLES.
// Define TWO_TO_FOUR_CNT_EN to add the saturating dec_count port.
module two_to_four_decoder_seq
    import two_to_four_decoder_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             e1,
    input  logic             e0,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy
`ifdef TWO_TO_FOUR_CNT_EN
    ,
    output logic [CNT_W-1:0] dec_count
`endif
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    onehot_t          onehot_q, onehot_d;
    onehot_t          dec_onehot;
    logic             accept;

    decode_2to4 u_decode (
        .code   ({e1, e0}),
        .onehot (dec_onehot)
    );

    // Flush wins over a same-cycle offer in IDLE.
    assign accept = (state_q == IDLE) && in_valid && !flush;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = HOLD;
                    cnt_d    = HOLD_LOAD;
                    onehot_d = dec_onehot;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    onehot_d = '0;
                end else if (cnt_q == '0) begin
                    onehot_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (flush || cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                onehot_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
        end
    end

`ifdef TWO_TO_FOUR_CNT_EN
    logic [CNT_W-1:0] dec_count_q, dec_count_d;

    always_comb begin
        dec_count_d = dec_count_q;
        if (accept && dec_count_q != '1) begin
            dec_count_d = dec_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_count_q <= '0;
        end else begin
            dec_count_q <= dec_count_d;
        end
    end

    assign dec_count = dec_count_q;
`endif

    assign {a, b, c, d} = onehot_q;
    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_two_to_four_decoder_seq.sv
// Self-checking bench: two instances (HOLD=4/GAP=1 and HOLD=1/GAP=0) against a timeline model.
module tb_two_to_four_decoder_seq;

    logic       clk = 1'b0;
    logic       rst_n, e1, e0, in_valid, flush;
    logic [1:0] a, b, c, d, in_ready, busy;
`ifdef TWO_TO_FOUR_CNT_EN
    logic [7:0] dec_count [2];
`endif

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    two_to_four_decoder_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .e1(e1), .e0(e0), .in_valid(in_valid),
        .in_ready(in_ready[0]), .flush(flush), .a(a[0]), .b(b[0]), .c(c[0]),
        .d(d[0]), .busy(busy[0])
`ifdef TWO_TO_FOUR_CNT_EN
        , .dec_count(dec_count[0])
`endif
    );

    two_to_four_decoder_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .e1(e1), .e0(e0), .in_valid(in_valid),
        .in_ready(in_ready[1]), .flush(flush), .a(a[1]), .b(b[1]), .c(c[1]),
        .d(d[1]), .busy(busy[1])
`ifdef TWO_TO_FOUR_CNT_EN
        , .dec_count(dec_count[1])
`endif
    );

    // Timeline model: each accepted code occupies edges [acc, acc+H+G) unless cut short.
    int         hh [2] = '{4, 1};
    int         gg [2] = '{1, 0};
    int         m_active [2];
    int         m_acc [2];
    int         m_end [2];
    int         m_cnt [2];
    logic [1:0] m_code [2];
    int         k = 0;

    function automatic bit m_busy(input int i);
        return m_active[i] != 0 && k >= m_acc[i] && k < m_end[i];
    endfunction

    function automatic logic [3:0] m_onehot(input int i);
        logic [3:0] one;
        one = 4'b0001;
        if (m_busy(i) && k < m_acc[i] + hh[i]) return one << m_code[i];
        return 4'b0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s @edge %0d: got %0h, want %0h", tag, k, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] code, input logic fl, input logic rn);
        logic [5:0] obs, exp;
        in_valid = v;
        {e1, e0} = code;
        flush    = fl;
        rst_n    = rn;
        for (int i = 0; i < 2; i++) begin
            if (!rn) begin
                m_active[i] = 0;
                m_cnt[i]    = 0;
            end else if (m_busy(i)) begin
                if (fl) m_end[i] = k + 1;
            end else if (v && !fl) begin
                m_active[i] = 1;
                m_acc[i]    = k + 1;
                m_end[i]    = k + 1 + hh[i] + gg[i];
                m_code[i]   = code;
                m_cnt[i]    = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
            end
        end
        @(posedge clk);
        k++;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            obs = {a[i], b[i], c[i], d[i], in_ready[i], busy[i]};
            exp = {m_onehot(i), !m_busy(i), m_busy(i)};
            check(i == 0 ? "dut0 abcd/ready/busy" : "dut1 abcd/ready/busy", 32'(obs), 32'(exp));
            check(i == 0 ? "dut0 onehot" : "dut1 onehot",
                  32'($countones({a[i], b[i], c[i], d[i]}) <= 1), 32'd1);
`ifdef TWO_TO_FOUR_CNT_EN
            check(i == 0 ? "dut0 dec_count" : "dut1 dec_count",
                  32'(dec_count[i]), 32'(m_cnt[i]));
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 2'b00, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 0; m_acc[i] = 0; m_end[i] = 0; m_cnt[i] = 0; m_code[i] = 2'b00;
        end
        rst_n = 1'b0; e1 = 1'b0; e0 = 1'b0; in_valid = 1'b0; flush = 1'b0;

        // Reset state
        step(1'b0, 2'b00, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0);

        // Single code 00: d for 4 cycles, 1 gap cycle, then ready
        step(1'b1, 2'b00, 1'b0, 1'b1);
        idle(7);

        // Codes 00..11 offered continuously so each lands on the first IDLE cycle
        for (int cd = 0; cd < 4; cd++)
            for (int j = 0; j < 6; j++) step(1'b1, 2'(cd), 1'b0, 1'b1);
        idle(6);

        // Flush on the 2nd HOLD cycle of code 11, then immediate code 10
        step(1'b1, 2'b11, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b1, 1'b1);
        step(1'b1, 2'b10, 1'b0, 1'b1);
        idle(6);

        // Reset during the 3rd HOLD cycle with a same-cycle offer
        step(1'b1, 2'b01, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        idle(3);

        // Continuous offers alternating 01 / 10 every two cycles
        for (int j = 0; j < 12; j++) step(1'b1, (j % 4 < 2) ? 2'b01 : 2'b10, 1'b0, 1'b1);
        idle(6);

        // Flush together with in_valid in IDLE: no transfer, no count
        step(1'b1, 2'b11, 1'b1, 1'b1);
        idle(2);

        // Drive the accepted-code counters to saturation
        for (int j = 0; j < 1570; j++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b1);
        step(1'b1, 2'b11, 1'b1, 1'b1);
        idle(6);

        // Randomized traffic with occasional flush and reset
        for (int j = 0; j < 600; j++)
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 39) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
